receptor_ps2: RTL and testbench

PS/2 keyboard receiver that sits directly upstream of the control/VGA/keyboard interconnect. It sits between the keyboard pins and the keyboard register that the PicoBlaze reads. It synchronizes and debounces the PS/2 clock and data lines, and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). It delivers validated make codes as a byte plus a one-cycle strobe, and absorbs the 0xF0 break prefix and the 0xE0 extended prefix.

---
 rtl/receptor_ps2_if.sv | 21 ++
 rtl/receptor_ps2.sv | 174 +++++++++++++++++
 tb/tb_receptor_ps2.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/receptor_ps2_if.sv
// Pin-side and register-side signals of the PS/2 receiver, bundled for port connection.
// master drives the pins and EN; slave is the receiver itself.
interface receptor_ps2_if;
  logic       ps2c;
  logic       DATA_IN;
  logic       EN;
  logic [7:0] DATA_OUT_TEC;
  logic       RX_DONE;
  logic       BREAK;
  logic       ERR;

  modport master (
    output ps2c, DATA_IN, EN,
    input  DATA_OUT_TEC, RX_DONE, BREAK, ERR
  );

  modport slave (
    input  ps2c, DATA_IN, EN,
    output DATA_OUT_TEC, RX_DONE, BREAK, ERR
  );
endinterface

// File: rtl/receptor_ps2.sv
// PS/2 keyboard receiver: synchronizes and debounces the pins, deframes 11-bit frames and
// delivers make/break scan codes, swallowing the 0xF0 and 0xE0 prefixes.
module receptor_ps2 #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 200000
) (
  input  logic          CLK,
  input  logic          RST,
  receptor_ps2_if.slave ps2
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Pin synchronizers; bit 1 is the synchronized value. Idle bus is high.
  logic [1:0] c_sync_q, d_sync_q;
  logic       c_s, d_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2.ps2c};
      d_sync_q <= {d_sync_q[0], ps2.DATA_IN};
    end
  end

  assign c_s = c_sync_q[1];
  assign d_s = d_sync_q[1];

  // Debounce: filt only moves once the whole window agrees.
  logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
  logic                  filt_q, filt_d;
  logic                  fall_tick;

  always_comb begin
    filt_sr_d = {filt_sr_q[FILTER_LEN-2:0], c_s};
    filt_d    = filt_q;
    if (&filt_sr_q) begin
      filt_d = 1'b1;
    end else if (filt_sr_q == '0) begin
      filt_d = 1'b0;
    end
    fall_tick = filt_q & ~filt_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      filt_sr_q <= '1;
      filt_q    <= 1'b1;
    end else begin
      filt_sr_q <= filt_sr_d;
      filt_q    <= filt_d;
    end
  end

  // Deframing state
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            brk_q, brk_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      data_q, data_d;
  logic            rx_done_q, rx_done_d;
  logic            break_q, break_d;
  logic            err_q, err_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    brk_d     = brk_q;
    data_d    = data_q;
    rx_done_d = 1'b0;
    break_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (state_q == StIdle || fall_tick) ? '0 : tmo_q + TmoW'(1);

    unique case (state_q)
      StIdle: begin
        // EN gates only the start bit; a frame already under way always completes.
        if (fall_tick && ps2.EN) begin
          if (!d_s) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StData: begin
        if (fall_tick) begin
          shift_d   = {d_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall_tick) begin
          par_d   = d_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall_tick) begin
          state_d = StIdle;
          if (d_s && (^{shift_q, par_q})) begin
            if (shift_q == CodeBreak) begin
              brk_d = 1'b1;
            end else if (shift_q != CodeExt) begin
              data_d    = shift_q;
              rx_done_d = 1'b1;
              break_d   = brk_q;
              brk_d     = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abandon a partial frame when ps2c stalls.
    if (state_q != StIdle && !fall_tick && tmo_q == TmoLast) begin
      state_d = StIdle;
      err_d   = 1'b1;
      brk_d   = 1'b0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      brk_q     <= 1'b0;
      tmo_q     <= '0;
      data_q    <= 8'h00;
      rx_done_q <= 1'b0;
      break_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      brk_q     <= brk_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      rx_done_q <= rx_done_d;
      break_q   <= break_d;
      err_q     <= err_d;
    end
  end

  assign ps2.DATA_OUT_TEC = data_q;
  assign ps2.RX_DONE      = rx_done_q;
  assign ps2.BREAK        = break_q;
  assign ps2.ERR          = err_q;

endmodule

// File: tb/tb_receptor_ps2.sv
// Self-checking bench for receptor_ps2: scoreboard of expected RX_DONE/ERR events
// drained by a negedge monitor, plus per-scenario inline checks.
module tb_receptor_ps2;

  localparam int unsigned F    = 8;
  localparam int unsigned T    = 1000;
  localparam int unsigned HALF = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  receptor_ps2_if bus ();

  receptor_ps2 #(
    .FILTER_LEN(F),
    .TIMEOUT   (T)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .ps2(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       brk;
  } ev_t;

  ev_t sb_q[$];
  ev_t ev;
  int  total = 0;
  int  bad   = 0;

  function automatic void exp_rx(input logic [7:0] d, input logic brk);
    ev_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.brk    = brk;
    sb_q.push_back(e);
  endfunction

  function automatic void exp_err();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    e.brk    = 1'b0;
    sb_q.push_back(e);
  endfunction

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (bus.RX_DONE === 1'b1 && bus.ERR === 1'b1) begin
        bad++;
        $display("FAIL strobes_exclusive RX_DONE=%b ERR=%b required not both 1", bus.RX_DONE,
                 bus.ERR);
      end
      total++;
      if (bus.RX_DONE !== 1'b1 && bus.BREAK !== 1'b0) begin
        bad++;
        $display("FAIL break_idle BREAK=%b required 0 while RX_DONE=0", bus.BREAK);
      end
      if (bus.RX_DONE === 1'b1 || bus.ERR === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event RX_DONE=%b ERR=%b data=%h required no event",
                   bus.RX_DONE, bus.ERR, bus.DATA_OUT_TEC);
        end else begin
          ev = sb_q.pop_front();
          if (bus.ERR !== ev.is_err ||
              (!ev.is_err && (bus.DATA_OUT_TEC !== ev.data || bus.BREAK !== ev.brk))) begin
            bad++;
            $display("FAIL event got err=%b data=%h brk=%b required err=%b data=%h brk=%b",
                     bus.ERR, bus.DATA_OUT_TEC, bus.BREAK, ev.is_err, ev.data, ev.brk);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One ps2c period: data set while high, then a falling edge.
  task automatic ps2_fall(input logic v);
    bus.DATA_IN = v;
    tick(HALF);
    bus.ps2c = 1'b0;
    tick(HALF);
    bus.ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v,
                            input logic en_drop);
    ps2_fall(1'b0);
    if (en_drop) bus.EN = 1'b0;
    for (int i = 0; i < 8; i++) ps2_fall(b[i]);
    ps2_fall(~(^b) ^ par_flip);
    ps2_fall(stop_v);
    bus.DATA_IN = 1'b1;
    tick(HALF);
  endtask

  task automatic test_reset();
    tick(5);
    total++;
    if (bus.DATA_OUT_TEC !== 8'h00 || bus.RX_DONE !== 1'b0 || bus.BREAK !== 1'b0 ||
        bus.ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs data=%h rx=%b brk=%b err=%b required 00 0 0 0",
               bus.DATA_OUT_TEC, bus.RX_DONE, bus.BREAK, bus.ERR);
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_frame();
    logic [7:0] b;
    b = 8'h1C;
    exp_rx(8'h1C, 1'b0);
    ps2_fall(1'b0);
    for (int i = 0; i < 8; i++) ps2_fall(b[i]);
    ps2_fall(1'b0);
    bus.DATA_IN = 1'b1;
    tick(HALF);
    bus.ps2c = 1'b0;
    repeat (F + 2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.RX_DONE !== 1'b0) begin
      bad++;
      $display("FAIL latency_early RX_DONE=%b required 0 before edge F+3", bus.RX_DONE);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.RX_DONE !== 1'b1 || bus.DATA_OUT_TEC !== 8'h1C) begin
      bad++;
      $display("FAIL latency RX_DONE=%b data=%h required 1 1c at edge F+3", bus.RX_DONE,
               bus.DATA_OUT_TEC);
    end
    tick(HALF);
    bus.ps2c = 1'b1;
    tick(HALF);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL frame_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    exp_rx(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    exp_rx(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    // Extended prefix must not disturb a pending break.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    exp_rx(8'h75, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    tick(20);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL break_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_bad_parity();
    exp_rx(8'h32, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    exp_err();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    total++;
    if (bus.DATA_OUT_TEC !== 8'h32) begin
      bad++;
      $display("FAIL parity_hold data=%h required 32", bus.DATA_OUT_TEC);
    end
    exp_err();
    send_frame(8'h32, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.DATA_OUT_TEC !== 8'h32) begin
      bad++;
      $display("FAIL stop_hold data=%h required 32", bus.DATA_OUT_TEC);
    end
    // A bad frame drops a pending break.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    exp_err();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    exp_rx(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    tick(20);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL parity_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    b = 8'h32;
    bus.DATA_IN = 1'b0;
    tick(5);
    bus.ps2c = 1'b0;
    tick(3);
    bus.ps2c = 1'b1;
    tick(5);
    bus.DATA_IN = 1'b1;
    tick(HALF);
    exp_rx(8'h32, 1'b0);
    ps2_fall(1'b0);
    ps2_fall(b[0]);
    ps2_fall(b[1]);
    tick(10);
    bus.ps2c = 1'b0;
    tick(3);
    bus.ps2c = 1'b1;
    tick(10);
    for (int i = 2; i < 8; i++) ps2_fall(b[i]);
    ps2_fall(~(^b));
    ps2_fall(1'b1);
    tick(HALF);
    total++;
    if (bus.DATA_OUT_TEC !== 8'h32) begin
      bad++;
      $display("FAIL glitch_data data=%h required 32", bus.DATA_OUT_TEC);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL glitch_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_timeout();
    exp_err();
    ps2_fall(1'b0);
    ps2_fall(1'b0);
    ps2_fall(1'b0);
    ps2_fall(1'b1);
    bus.DATA_IN = 1'b1;
    tick(HALF);
    bus.ps2c = 1'b0;
    repeat (F + 2 + T) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.ERR !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early ERR=%b required 0 one cycle before TIMEOUT", bus.ERR);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.ERR !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err ERR=%b required 1 at TIMEOUT", bus.ERR);
    end
    bus.ps2c = 1'b1;
    tick(HALF);
    total++;
    if (bus.DATA_OUT_TEC !== 8'h32) begin
      bad++;
      $display("FAIL timeout_hold data=%h required 32", bus.DATA_OUT_TEC);
    end
    exp_rx(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    tick(20);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    ps2_fall(1'b0);
    ps2_fall(1'b0);
    ps2_fall(1'b0);
    ps2_fall(1'b1);
    ps2_fall(1'b1);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.DATA_OUT_TEC !== 8'h00 || bus.RX_DONE !== 1'b0 || bus.BREAK !== 1'b0 ||
        bus.ERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid data=%h rx=%b brk=%b err=%b required 00 0 0 0",
               bus.DATA_OUT_TEC, bus.RX_DONE, bus.BREAK, bus.ERR);
    end
    tick(5);
    rst_n = 1'b1;
    tick(5);
    exp_rx(8'h32, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    tick(20);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_enable();
    bus.EN = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    bus.EN = 1'b1;
    tick(20);
    total++;
    if (bus.DATA_OUT_TEC !== 8'h32) begin
      bad++;
      $display("FAIL en_ignored data=%h required 32", bus.DATA_OUT_TEC);
    end
    exp_rx(8'h4D, 1'b0);
    send_frame(8'h4D, 1'b0, 1'b1, 1'b1);
    bus.EN = 1'b1;
    tick(20);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL en_drop_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_rx(8'h1C, 1'b0);
    exp_rx(8'h32, 1'b0);
    exp_rx(8'h5A, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    tick(20);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain pending=%0d required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    bus.ps2c    = 1'b1;
    bus.DATA_IN = 1'b1;
    bus.EN      = 1'b1;
    test_reset();
    test_frame();
    test_break();
    test_bad_parity();
    test_glitch();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
